// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for a CIC decimator: holds a requested ratio until an output-sample boundary, applies it, then blanks the settling outputs.
// Build option: define CIC_RATE_CTRL_INIT_EN to push DEFAULT_RATE to the decimator and settle right after reset.
module cic_rate_ctrl #(
    parameter int RATE_DW      = 16,
    parameter int R_MIN        = 2,
    parameter int R_MAX        = 10,
    parameter int CIC_N        = 7,
    parameter int DEFAULT_RATE = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
    input  logic               s_axis_cfg_tvalid,
    output logic               s_axis_cfg_tready,
    input  logic               s_axis_in_tvalid,
    input  logic               cic_out_tvalid,
    output logic [RATE_DW-1:0] m_axis_rate_tdata,
    output logic               m_axis_rate_tvalid,
    output logic               m_axis_out_tvalid,
    output logic [RATE_DW-1:0] current_rate,
    output logic               busy,
    output logic               cfg_err,
    output logic               timeout,
    output logic [15:0]        dropped_cnt
);

    localparam int TO_W = $clog2(2 * R_MAX + 1);
    localparam int ST_W = $clog2(CIC_N + 1);
    localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(2 * R_MAX - 1);
    localparam logic [ST_W-1:0]    SETTLE_LOAD = ST_W'(CIC_N);
    localparam logic [RATE_DW-1:0] RATE_LO     = RATE_DW'(R_MIN);
    localparam logic [RATE_DW-1:0] RATE_HI     = RATE_DW'(R_MAX);
    localparam logic [RATE_DW-1:0] RATE_RST    = RATE_DW'(DEFAULT_RATE);

    typedef enum logic [1:0] {IDLE, WAIT_BOUNDARY, APPLY, SETTLE} state_t;

    state_t             state_q, state_d;
    logic [RATE_DW-1:0] pending_q;
    logic [RATE_DW-1:0] rate_tdata_q;
    logic [RATE_DW-1:0] current_rate_q;
    logic               rate_tvalid_q;
    logic               busy_q;
    logic               cfg_err_q;
    logic               timeout_q;
    logic [15:0]        dropped_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [ST_W-1:0]    settle_q;

    logic cfg_fire;
    logic cfg_ok;
    logic to_hit;
    logic gate_closed;
    logic drop_ev;

    assign cfg_fire    = (state_q == IDLE) && s_axis_cfg_tvalid;
    assign cfg_ok      = (s_axis_cfg_tdata >= RATE_LO) && (s_axis_cfg_tdata <= RATE_HI);
    assign to_hit      = s_axis_in_tvalid && (to_cnt_q == TO_LAST);
    assign gate_closed = (state_q == APPLY) || (state_q == SETTLE);
    assign drop_ev     = gate_closed && cic_out_tvalid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (cfg_fire && cfg_ok) state_d = WAIT_BOUNDARY;
            WAIT_BOUNDARY: if (cic_out_tvalid || to_hit) state_d = APPLY;
            APPLY:         state_d = SETTLE;
            SETTLE:        if (settle_q == '0) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef CIC_RATE_CTRL_INIT_EN
            state_q       <= APPLY;
            rate_tvalid_q <= 1'b1;
            settle_q      <= SETTLE_LOAD;
            busy_q        <= 1'b1;
`else
            state_q       <= IDLE;
            rate_tvalid_q <= 1'b0;
            settle_q      <= '0;
            busy_q        <= 1'b0;
`endif
            pending_q      <= RATE_RST;
            rate_tdata_q   <= RATE_RST;
            current_rate_q <= RATE_RST;
            cfg_err_q      <= 1'b0;
            timeout_q      <= 1'b0;
            dropped_q      <= '0;
            to_cnt_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= (state_d != IDLE);
            rate_tvalid_q <= (state_d == APPLY);
            cfg_err_q     <= cfg_fire && !cfg_ok;
            // A real boundary in the same cycle wins over the timeout.
            timeout_q     <= (state_q == WAIT_BOUNDARY) && to_hit && !cic_out_tvalid;

            if (cfg_fire && cfg_ok)
                pending_q <= s_axis_cfg_tdata;

            if (state_q == WAIT_BOUNDARY && state_d == APPLY) begin
                rate_tdata_q   <= pending_q;
                current_rate_q <= pending_q;
            end

            if (state_q != WAIT_BOUNDARY)
                to_cnt_q <= '0;
            else if (s_axis_in_tvalid)
                to_cnt_q <= to_cnt_q + 1'b1;

            if (state_q == WAIT_BOUNDARY && state_d == APPLY)
                settle_q <= SETTLE_LOAD;
            else if (drop_ev && settle_q != '0)
                settle_q <= settle_q - 1'b1;

            if (drop_ev && dropped_q != 16'hFFFF)
                dropped_q <= dropped_q + 16'd1;
        end
    end

    assign s_axis_cfg_tready  = (state_q == IDLE);
    assign m_axis_out_tvalid  = cic_out_tvalid && !gate_closed;
    assign m_axis_rate_tdata  = rate_tdata_q;
    assign m_axis_rate_tvalid = rate_tvalid_q;
    assign current_rate       = current_rate_q;
    assign busy               = busy_q;
    assign cfg_err            = cfg_err_q;
    assign timeout            = timeout_q;
    assign dropped_cnt        = dropped_q;

endmodule
